// File: rtl/acc_c_rr_scheduler.sv
// acc_c_rr_scheduler
//   Shares one accelerator C-channel responder between NumReq requesters.
//   Request path: round-robin arbiter with grant locking while the responder
//   stalls. Every request that expects a response pushes the issuing
//   requester ID into an in-order FIFO. Each response is routed back to the
//   ID at the FIFO head.
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   slv_req_valid_i/ready_o/data_i    per-requester request channel
//   slv_req_norsp_i                   request produces no response
//   mst_req_valid_o/ready_i/data_o    shared request channel to responder
//   mst_rsp_valid_i/ready_o/data_i    shared response channel from responder
//   slv_rsp_valid_o/ready_i/data_o    per-requester response channel
//   outst_cnt_o                       tracked requests awaiting response
module acc_c_rr_scheduler #(
  parameter int NumReq   = 4,
  parameter int ReqWidth = 64,
  parameter int RspWidth = 40,
  parameter int MaxOutst = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                slv_req_valid_i,
  output logic [NumReq-1:0]                slv_req_ready_o,
  input  logic [NumReq*ReqWidth-1:0]       slv_req_data_i,
  input  logic [NumReq-1:0]                slv_req_norsp_i,
  output logic                             mst_req_valid_o,
  input  logic                             mst_req_ready_i,
  output logic [ReqWidth-1:0]              mst_req_data_o,
  input  logic                             mst_rsp_valid_i,
  output logic                             mst_rsp_ready_o,
  input  logic [RspWidth-1:0]              mst_rsp_data_i,
  output logic [NumReq-1:0]                slv_rsp_valid_o,
  input  logic [NumReq-1:0]                slv_rsp_ready_i,
  output logic [RspWidth-1:0]              slv_rsp_data_o,
  output logic [$clog2(MaxOutst+1)-1:0]    outst_cnt_o
);

  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
  localparam int CntW = $clog2(MaxOutst + 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e          lock_q, lock_d;
  logic [IdW-1:0]       lock_idx_q, lock_idx_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdW-1:0]       fifo_q [MaxOutst];
  logic [IdW-1:0]       fifo_d [MaxOutst];

  logic [IdW-1:0]       rr_pick;
  logic [IdW-1:0]       scan_idx;
  logic                 found;
  logic [IdW-1:0]       grant;
  logic                 can_issue;
  logic                 req_hs;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [IdW-1:0]       head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutst - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Request arbitration: first valid requester at or after the rr pointer.
  always_comb begin
    rr_pick  = rr_ptr_q;
    scan_idx = rr_ptr_q;
    found    = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = IdW'((int'(rr_ptr_q) + k) % NumReq);
      if (!found && slv_req_valid_i[scan_idx]) begin
        found   = 1'b1;
        rr_pick = scan_idx;
      end
    end
  end

  always_comb begin
    grant = (lock_q == LOCKED) ? lock_idx_q : rr_pick;
    // A full tracker blocks issue even if a pop happens this cycle; the
    // rst_ni term keeps every handshake output low while reset is held.
    can_issue       = rst_ni && (cnt_q < CntW'(MaxOutst));
    mst_req_valid_o = can_issue & slv_req_valid_i[grant];
    mst_req_data_o  = slv_req_data_i[int'(grant)*ReqWidth +: ReqWidth];
    slv_req_ready_o        = '0;
    slv_req_ready_o[grant] = can_issue & mst_req_ready_i;
    req_hs = mst_req_valid_o & mst_req_ready_i;
    push   = req_hs & ~slv_req_norsp_i[grant];
  end

  // Response routing from the FIFO head.
  always_comb begin
    fifo_empty      = (cnt_q == '0);
    head            = fifo_q[rd_ptr_q];
    slv_rsp_valid_o = '0;
    mst_rsp_ready_o = 1'b0;
    if (!fifo_empty) begin
      slv_rsp_valid_o[head] = mst_rsp_valid_i;
      mst_rsp_ready_o       = slv_rsp_ready_i[head];
    end
    slv_rsp_data_o = mst_rsp_data_i;
    pop            = mst_rsp_valid_i & mst_rsp_ready_o;
  end

  // Next state: lock FSM, rr pointer, ID FIFO and counter.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    fifo_d     = fifo_q;
    case (lock_q)
      UNLOCKED: begin
        if (mst_req_valid_o && !mst_req_ready_i) begin
          lock_d     = LOCKED;
          lock_idx_d = grant;
        end
      end
      LOCKED: begin
        if (req_hs) lock_d = UNLOCKED;
      end
      default: lock_d = UNLOCKED;
    endcase
    if (req_hs) begin
      rr_ptr_d = (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // ID storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign outst_cnt_o = cnt_q;

`ifndef SYNTHESIS
  a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_empty |-> !mst_rsp_valid_i);
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_req_valid_o && !mst_req_ready_i) |=>
      (mst_req_valid_o && $stable(mst_req_data_o)));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxOutst));
`endif

endmodule
